// File: rtl/round_robin_fp_pkg.sv
// Shared definitions for the fixed-priority / round-robin arbiter:
// FSM state encoding, owner-class codes and the default grant timeout.
package round_robin_fp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    localparam logic [1:0] ACT_NONE = 2'b00;
    localparam logic [1:0] ACT_H    = 2'b01;
    localparam logic [1:0] ACT_L    = 2'b10;

    localparam int TIMEOUT_DEFAULT = 32;

endpackage

// File: rtl/round_robin_fp_rr_pick.sv
// Round-robin picker: finds the first set request bit at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_pick
    import round_robin_fp_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic         valid,
    output logic [3:0]   idx
);

    // Upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1];
    // within each segment the lowest index wins.
    always_comb begin
        valid = 1'b0;
        idx   = 4'd0;
        for (int j = 0; j < N; j++) begin
            if (!valid && req[j] && (4'(j) >= ptr)) begin
                valid = 1'b1;
                idx   = 4'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!valid && req[j] && (4'(j) < ptr)) begin
                valid = 1'b1;
                idx   = 4'(j);
            end
        end
    end

endmodule

// File: rtl/round_robin_fp.sv
// Arbiter for one shared transmitter: a high-priority requester H always
// beats the N low-priority requesters, which share what is left in
// round-robin order. Grants use a ready / active-low enable / go handshake
// with a timeout on the wait for go. All outputs are registered.
module round_robin_fp
    import round_robin_fp_pkg::*;
#(
    parameter int N       = 2,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bool_ready_H,
    input  logic         bool_go_H,
    input  logic [N-1:0] bool_ready_L,
    input  logic [N-1:0] bool_go_L,
    output logic         ena_n_H,
    output logic [N-1:0] ena_n_L,
    output logic [1:0]   active,
    output logic [3:0]   channel
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [3:0]       rr_ptr;

    logic             pick_valid;
    logic [3:0]       pick_idx;
    logic [N-1:0]     pick_onehot;
    logic             l_go;
    logic             l_ready;
    logic             win_go;
    logic             win_ready;
    logic             leave;
    logic [3:0]       next_ptr;

    rr_pick #(.N(N)) u_rr_pick (
        .req   (bool_ready_L),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Select the current owner's handshake inputs; other requesters' go is ignored.
    always_comb begin
        l_go        = 1'b0;
        l_ready     = 1'b0;
        pick_onehot = '0;
        for (int j = 0; j < N; j++) begin
            if (channel == 4'(j)) begin
                l_go    = bool_go_L[j];
                l_ready = bool_ready_L[j];
            end
            pick_onehot[j] = (pick_idx == 4'(j));
        end
        win_go    = (active == ACT_H) ? bool_go_H    : l_go;
        win_ready = (active == ACT_H) ? bool_ready_H : l_ready;
        // A grant ends on completion (go falls in BUSY), withdrawal or timeout.
        leave     = ((state == GRANT) && !win_go && (!win_ready || (count == '0))) ||
                    ((state == BUSY)  && !win_go);
        next_ptr  = (channel == 4'(N - 1)) ? 4'd0 : channel + 4'd1;
    end

    // Arbitration FSM with registered enables, owner outputs, counter and pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            rr_ptr  <= 4'd0;
            ena_n_H <= 1'b1;
            ena_n_L <= '1;
            active  <= ACT_NONE;
            channel <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bool_ready_H) begin
                        state   <= GRANT;
                        count   <= CNT_W'(TIMEOUT);
                        ena_n_H <= 1'b0;
                        active  <= ACT_H;
                        channel <= 4'd0;
                    end else if (pick_valid) begin
                        state   <= GRANT;
                        count   <= CNT_W'(TIMEOUT);
                        ena_n_L <= ~pick_onehot;
                        active  <= ACT_L;
                        channel <= pick_idx;
                    end
                end
                GRANT: begin
                    if (win_go) begin
                        state   <= BUSY;
                        ena_n_H <= 1'b1;
                        ena_n_L <= '1;
                    end else if (!leave) begin
                        count <= count - 1'b1;
                    end
                end
                BUSY: ;
                default: state <= IDLE;
            endcase

            if (leave) begin
                state   <= IDLE;
                ena_n_H <= 1'b1;
                ena_n_L <= '1;
                active  <= ACT_NONE;
                channel <= 4'd0;
                if (active == ACT_L) begin
                    rr_ptr <= next_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_round_robin_fp.sv
// Bench for round_robin_fp: directed scenarios followed by randomized
// traffic compared cycle by cycle against a behavioural owner model.
module tb_round_robin_fp;

    localparam int N       = 2;
    localparam int TIMEOUT = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rH = 1'b0;
    logic         gH = 1'b0;
    logic [N-1:0] rL = '0;
    logic [N-1:0] gL = '0;
    logic         ena_n_H;
    logic [N-1:0] ena_n_L;
    logic [1:0]   active;
    logic [3:0]   channel;

    int errors = 0;
    int checks = 0;

    // Reference model: owner class (0 none, 1 H, 2 L), L index, in-use flag,
    // cycles waited for go, and next L index to favour.
    int m_cls, m_idx, m_busy, m_wait, m_ptr;

    always #5 clk = ~clk;

    round_robin_fp #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bool_ready_H (rH),
        .bool_go_H    (gH),
        .bool_ready_L (rL),
        .bool_go_L    (gL),
        .ena_n_H      (ena_n_H),
        .ena_n_L      (ena_n_L),
        .active       (active),
        .channel      (channel)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_cls = 0; m_idx = 0; m_busy = 0; m_wait = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        int  go_w, rdy_w;
        bit  rel;
        rel = 1'b0;
        if (m_cls == 0) begin
            if (rH) begin
                m_cls = 1; m_idx = 0; m_busy = 0; m_wait = 0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (m_cls == 0 && ((rL >> j) & 1) != 0) begin
                        m_cls = 2; m_idx = j; m_busy = 0; m_wait = 0;
                    end
                end
            end
        end else begin
            go_w  = (m_cls == 1) ? int'(gH) : int'((gL >> m_idx) & 1);
            rdy_w = (m_cls == 1) ? int'(rH) : int'((rL >> m_idx) & 1);
            if (m_busy != 0) begin
                if (go_w == 0) rel = 1'b1;
            end else if (go_w != 0) begin
                m_busy = 1;
            end else if (rdy_w == 0) begin
                rel = 1'b1;
            end else if (m_wait == TIMEOUT) begin
                rel = 1'b1;
            end else begin
                m_wait++;
            end
            if (rel) begin
                if (m_cls == 2) m_ptr = (m_idx + 1) % N;
                m_cls = 0; m_idx = 0; m_busy = 0; m_wait = 0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (ena_n_H !== 1'b1 || ena_n_L !== 2'b11 || active !== 2'b00 || channel !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: ena_n_H=%b ena_n_L=%b active=%b channel=%0d, want 1 11 00 0",
                     ena_n_H, ena_n_L, active, channel);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (ena_n_H !== 1'b1 || ena_n_L !== 2'b11 || active !== 2'b00 || channel !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle: ena_n_H=%b ena_n_L=%b active=%b channel=%0d, want 1 11 00 0",
                     ena_n_H, ena_n_L, active, channel);
        end
    endtask

    task automatic test_h_only();
        rH = 1'b1;
        step();
        checks++;
        if (ena_n_H !== 1'b0 || active !== 2'b01 || ena_n_L !== 2'b11) begin
            errors++;
            $display("FAIL h_grant: ena_n_H=%b active=%b ena_n_L=%b, want 0 01 11", ena_n_H, active, ena_n_L);
        end
        gH = 1'b1;
        step();
        checks++;
        if (ena_n_H !== 1'b1 || active !== 2'b01) begin
            errors++;
            $display("FAIL h_busy: ena_n_H=%b active=%b, want 1 01", ena_n_H, active);
        end
        gH = 1'b0; rH = 1'b0;
        step();
        checks++;
        if (ena_n_H !== 1'b1 || active !== 2'b00) begin
            errors++;
            $display("FAIL h_done: ena_n_H=%b active=%b, want 1 00", ena_n_H, active);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want_ch [3];
        want_ch[0] = 4'd0; want_ch[1] = 4'd1; want_ch[2] = 4'd0;
        rL = 2'b11;
        for (int g = 0; g < 3; g++) begin
            step();
            checks++;
            if (channel !== want_ch[g] || active !== 2'b10 ||
                ena_n_L !== ~(2'b01 << want_ch[g])) begin
                errors++;
                $display("FAIL rr_grant%0d: channel=%0d active=%b ena_n_L=%b, want channel %0d active 10",
                         g, channel, active, ena_n_L, want_ch[g]);
            end
            gL = 2'b01 << want_ch[g];
            step();
            gL = 2'b00;
            if (g == 2) rL = 2'b00;
            step();
            checks++;
            if (active !== 2'b00 || ena_n_L !== 2'b11) begin
                errors++;
                $display("FAIL rr_idle%0d: active=%b ena_n_L=%b, want 00 11", g, active, ena_n_L);
            end
        end
    endtask

    task automatic test_priority();
        rL = 2'b11;
        step();
        gL = 2'b10;
        step();
        rH = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (ena_n_H !== 1'b1 || active !== 2'b10 || channel !== 4'd1) begin
                errors++;
                $display("FAIL prio_no_preempt%0d: ena_n_H=%b active=%b channel=%0d, want 1 10 1",
                         c, ena_n_H, active, channel);
            end
        end
        gL = 2'b00;
        step();
        step();
        checks++;
        if (ena_n_H !== 1'b0 || active !== 2'b01 || ena_n_L !== 2'b11 || channel !== 4'd0) begin
            errors++;
            $display("FAIL prio_h_wins: ena_n_H=%b active=%b ena_n_L=%b channel=%0d, want 0 01 11 0",
                     ena_n_H, active, ena_n_L, channel);
        end
        gH = 1'b1;
        step();
        gH = 1'b0; rH = 1'b0; rL = 2'b00;
        step();
    endtask

    task automatic test_timeout();
        int cnt;
        rL = 2'b01;
        step();
        rL = 2'b11;
        cnt = 0;
        while (ena_n_L[0] === 1'b0 && cnt < 100) begin
            cnt++;
            step();
        end
        checks++;
        if (cnt != TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_len: enable low %0d cycles, want %0d", cnt, TIMEOUT + 1);
        end
        checks++;
        if (active !== 2'b00 || ena_n_L !== 2'b11) begin
            errors++;
            $display("FAIL timeout_idle: active=%b ena_n_L=%b, want 00 11", active, ena_n_L);
        end
        step();
        checks++;
        if (channel !== 4'd1 || ena_n_L !== 2'b01 || active !== 2'b10) begin
            errors++;
            $display("FAIL timeout_next: channel=%0d ena_n_L=%b active=%b, want 1 01 10",
                     channel, ena_n_L, active);
        end
        gL = 2'b10;
        step();
        gL = 2'b00; rL = 2'b00;
        step();
    endtask

    task automatic test_early_drop();
        rL = 2'b01;
        step();
        gL = 2'b01;
        step();
        rL = 2'b00;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (active !== 2'b10 || channel !== 4'd0 || ena_n_L !== 2'b11) begin
                errors++;
                $display("FAIL early_drop%0d: active=%b channel=%0d ena_n_L=%b, want 10 0 11",
                         c, active, channel, ena_n_L);
            end
        end
        gL = 2'b00;
        step();
        checks++;
        if (active !== 2'b00) begin
            errors++;
            $display("FAIL early_drop_done: active=%b, want 00", active);
        end
    endtask

    task automatic test_reset_async();
        rL = 2'b01;
        step();
        checks++;
        if (ena_n_L !== 2'b10) begin
            errors++;
            $display("FAIL async_pre: ena_n_L=%b, want 10", ena_n_L);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ena_n_L !== 2'b11 || ena_n_H !== 1'b1 || active !== 2'b00 || channel !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: ena_n_H=%b ena_n_L=%b active=%b channel=%0d, want 1 11 00 0",
                     ena_n_H, ena_n_L, active, channel);
        end
        rL = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic         e_h;
        logic [N-1:0] e_l;
        logic [1:0]   e_act;
        logic [3:0]   e_ch;
        int           go_div;
        rst_n = 1'b0;
        rH = 1'b0; gH = 1'b0; rL = '0; gL = '0;
        step();
        rst_n = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 900; cyc++) begin
            go_div = (cyc < 450) ? 2 : 60;
            if ($urandom_range(0, 7) == 0) rH = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) rL = N'($urandom);
            gH = ($urandom_range(0, go_div - 1) == 0) ? ~gH : gH;
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(0, go_div - 1) == 0) gL[j] = ~gL[j];
            end
            model_step();
            step();
            e_h   = !(m_cls == 1 && m_busy == 0);
            e_l   = (m_cls == 2 && m_busy == 0) ? ~(N'(1) << m_idx) : '1;
            e_act = 2'(m_cls);
            e_ch  = (m_cls == 2) ? 4'(m_idx) : 4'd0;
            checks++;
            if (ena_n_H !== e_h || ena_n_L !== e_l || active !== e_act || channel !== e_ch) begin
                errors++;
                $display("FAIL random@%0d: ena_n_H=%b ena_n_L=%b active=%b channel=%0d, want %b %b %b %0d",
                         cyc, ena_n_H, ena_n_L, active, channel, e_h, e_l, e_act, e_ch);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_h_only();
        test_round_robin();
        test_priority();
        test_timeout();
        test_early_drop();
        test_reset_async();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_robin_fp.md
# round_robin_fp

Fixed-priority plus round-robin arbiter granting one shared resource to one high-priority requester (H) and `N` low-priority requesters (L). H always wins over L. The L requesters share the remaining bandwidth in round-robin order. Each requester uses a ready/enable/go handshake: it raises `ready`, the arbiter drives its active-low enable, and the requester signals ownership with `go`. The block sits between time-triggered (H) and rate-constrained (L) traffic sources and the shared transmitter.

## Interface
- `N`, default 2: number of L requesters; legal range 1..16.
- `TIMEOUT`, default 32: cycles a grant waits for `go` before it is withdrawn.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `bool_ready_H` in 1: H requests the resource.
- `bool_go_H` in 1: H is using the resource.
- `bool_ready_L` in N: per-L request.
- `bool_go_L` in N: per-L in-use.
- `ena_n_H` out 1: active-low grant to H.
- `ena_n_L` out N: active-low grants to L; at most one is low.
- `active` out 2: current owner class; 00 = none, 01 = H, 10 = L; 11 is never driven.
- `channel` out 4: index of the granted L requester; 0 when the owner is H or there is no owner.

## Operation
- FSM states: IDLE, GRANT, BUSY.
- **IDLE**:
  - If `bool_ready_H` is high, grant H.
  - Otherwise, if any `bool_ready_L` bit is high, grant the first ready L at or after `rr_ptr`, searching upward with wrap modulo N.
  - Otherwise stay in IDLE.
  - On a grant, go to GRANT, load the timeout counter with `TIMEOUT`, and drive the winner's `ena_n` low, `active`, and `channel`.
- **GRANT**: the winner's `ena_n` stays low.
  - If the winner's `go` is high, go to BUSY and release `ena_n` high.
  - Else, if the winner's `ready` is low (request withdrawn), go to IDLE.
  - Else, if the counter equals 0 (timeout), go to IDLE.
  - Otherwise decrement the counter.
- **BUSY**: all `ena_n` are high. When the winner's `go` is low, go to IDLE.
- **Owner outputs**: `active` and `channel` hold their value throughout GRANT and BUSY. They return to 00 / 0 on entering IDLE.
- **Round-robin pointer** (`rr_ptr`, reset 0): when an L grant leaves GRANT or BUSY for any reason (completion, withdrawal, timeout), set `rr_ptr = (granted index + 1) mod N`. H grants do not move `rr_ptr`.
- **No preemption**: a ready H waits until the current L owner completes.
- **Completion** is defined only by `go` falling. `ready` dropping during BUSY is ignored.
- **Inactive inputs**: `go` from non-granted requesters is ignored.
- **Reset values**: all `ena_n` = 1, `active` = 00, `channel` = 0, state = IDLE, `rr_ptr` = 0, counter = 0.

## Timing
- All outputs are registered.
- **Grant latency**: `ready` sampled high at edge k in IDLE gives `ena_n` low after edge k.
- **Enable release**: `go` sampled high at edge m gives `ena_n` high after edge m.
- **Re-arbitration**: `go` sampled low in BUSY at edge p gives IDLE after edge p; the next grant can issue after edge p+1. There is one idle cycle between owners.
- **Timeout**: the grant is withdrawn `TIMEOUT`+1 cycles after `ena_n` went low if no `go` is seen.
- **Simultaneous events**: H and L ready on the same edge gives H. Multiple L ready resolves by `rr_ptr`.
- **Reset mid-operation**: all `ena_n` release immediately and asynchronously.

## Structure
- Shared package holds: the FSM state enum, the `active` codes (ACT_NONE = 00, ACT_H = 01, ACT_L = 10), and the default `TIMEOUT`.
- One natural sub-module, `rr_pick`: combinational, N-bit request vector plus pointer in, valid flag plus index out.

## Test plan
- **H only**, N=2: `bool_ready_H` rises → `ena_n_H` low next cycle, `active` = 01. H raises `go` → `ena_n_H` high. H drops `go` → `active` = 00.
- **Round-robin**: L0 and L1 both ready and keep-type (ready stays high), `rr_ptr` = 0 → grants alternate L0, L1, L0, with `channel` = 0, 1, 0.
- **Priority**: H ready while L1 is BUSY → H is not granted until L1's `go` falls. Then H wins over a still-ready L0 and `active` = 01.
- **Timeout**: L0 ready but never raises `go`, `TIMEOUT` = 32 → `ena_n_L[0]` low for 33 cycles, then IDLE. `rr_ptr` = 1, so a ready L1 is granted next.
- **Early ready drop**: L0 drops `ready` during BUSY while `go` is still high → still owner until `go` falls.
- **Reset**: `rst_n` low during GRANT → `ena_n` all high and `active` = 00 without waiting for a clock edge.
